// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned DEF_TIMEOUT      = 15;

  // Controller states: one idle arbitration state and one state per requester.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PIPE = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Read data returned to a requester: real data on mem_ready, zero on timeout.
  function automatic logic [DATA_W-1:0] read_result(input logic ready,
                                                     input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] res;
    if (ready) begin
      res = rdata;
    end else begin
      res = {DATA_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the access controller: strobe/address/data out, data/ready back.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_access_timer.sv
// Per-access cycle counter. Cleared when an access is granted, it counts the
// cycles of the running access and flags the last allowed cycle.
module mem_access_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic timeout_hit
);

  localparam int unsigned   TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // The access has used TIMEOUT cycles once the current cycle is the last one.
  assign timeout_hit = active & (cnt_q == LIMIT);

  // Next count: clear on grant, advance while an access is running.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = {TW{1'b0}};
    end else if (active && !timeout_hit) begin
      cnt_d = cnt_q + TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates a single memory port between the CPU pipeline and a loader/debug
// port. The pipeline wins by default; the loader is forced in after
// STARVE_LIMIT consecutive pipeline grants. Every access is bounded by TIMEOUT.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  // pipeline side
  input  logic               MemReadE,
  input  logic               MemWriteE,
  input  logic [ADDR_W-1:0]  ALUOutE,
  input  logic [DATA_W-1:0]  StoreConverterE,
  output logic               StallM,
  output logic [DATA_W-1:0]  DataMemOutW,
  // loader side
  input  logic               ld_req,
  input  logic               ld_we,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_wdata,
  output logic               ld_gnt,
  output logic [DATA_W-1:0]  ld_rdata,
  output logic               ld_done,
  // memory side
  mem_access_ctrl_if.master  mem,
  output logic               mem_timeout
);

  localparam int unsigned   SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] ldr_q, ldr_d;
  logic              ld_gnt_q, ld_gnt_d;
  logic              ld_done_q, ld_done_d;
  logic              timeout_q, timeout_d;

  logic pipe_req;
  logic ld_req_eff;
  logic grant_pipe;
  logic grant_load;
  logic busy;
  logic access_end;
  logic timeout_hit;

  assign pipe_req = MemReadE | MemWriteE;
  assign busy     = (state_q != IDLE);

  mem_access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (grant_pipe | grant_load),
    .active      (busy),
    .timeout_hit (timeout_hit)
  );

  // Arbitration in IDLE. The loader request is masked while ld_done is showing,
  // so a loader that has not yet dropped ld_req is not granted a second time.
  always_comb begin
    ld_req_eff = ld_req & ~ld_done_q;
    grant_pipe = 1'b0;
    grant_load = 1'b0;
    access_end = 1'b0;
    if (state_q == IDLE) begin
      grant_pipe = pipe_req & ~(ld_req_eff & (starve_q == STARVE_MAX));
      grant_load = ld_req_eff & ~grant_pipe;
    end else begin
      access_end = mem.mem_ready | timeout_hit;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE when the access ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_pipe) begin
          state_d = PIPE;
        end else if (grant_load) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      PIPE, LOAD: begin
        if (access_end) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: counts pipeline grants made while the loader waits.
  always_comb begin
    starve_d = starve_q;
    if (!ld_req) begin
      starve_d = {SW{1'b0}};
    end else if (grant_load) begin
      starve_d = {SW{1'b0}};
    end else if (grant_pipe && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Access capture on grant; a simultaneous read+write request is a write.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (grant_pipe) begin
      addr_d  = ALUOutE;
      wdata_d = StoreConverterE;
      we_d    = MemWriteE;
    end else if (grant_load) begin
      addr_d  = ld_addr;
      wdata_d = ld_wdata;
      we_d    = ld_we;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
    end
  end

  // Completion results: read data, handshake pulses and the sticky timeout.
  always_comb begin
    dout_d    = dout_q;
    ldr_d     = ldr_q;
    ld_gnt_d  = grant_load;
    ld_done_d = 1'b0;
    timeout_d = timeout_q;
    if (access_end) begin
      timeout_d = timeout_q | ~mem.mem_ready;
      if ((state_q == PIPE) && !we_q) begin
        dout_d = read_result(mem.mem_ready, mem.mem_rdata);
      end else begin
        dout_d = dout_q;
      end
      if (state_q == LOAD) begin
        ld_done_d = 1'b1;
        if (!we_q) begin
          ldr_d = read_result(mem.mem_ready, mem.mem_rdata);
        end else begin
          ldr_d = ldr_q;
        end
      end else begin
        ld_done_d = 1'b0;
      end
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= {SW{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      we_q      <= 1'b0;
      dout_q    <= {DATA_W{1'b0}};
      ldr_q     <= {DATA_W{1'b0}};
      ld_gnt_q  <= 1'b0;
      ld_done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      dout_q    <= dout_d;
      ldr_q     <= ldr_d;
      ld_gnt_q  <= ld_gnt_d;
      ld_done_q <= ld_done_d;
      timeout_q <= timeout_d;
    end
  end

  // The pipeline is released in the cycle its own access completes.
  assign StallM        = pipe_req & ~((state_q == PIPE) & (mem.mem_ready | timeout_hit));
  assign DataMemOutW   = dout_q;
  assign ld_gnt        = ld_gnt_q;
  assign ld_done       = ld_done_q;
  assign ld_rdata      = ldr_q;
  assign mem_timeout   = timeout_q;
  assign mem.mem_req   = busy;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl (STARVE_LIMIT=2, TIMEOUT=4).
// A transaction-level model predicts the winner of each arbitration, the bus
// contents during the access and the results visible after completion.
module tb_mem_access_ctrl;

  localparam int unsigned SL = 2;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadE = 1'b0, MemWriteE = 1'b0;
  logic [31:0] ALUOutE = 32'h0, StoreConverterE = 32'h0;
  logic        StallM;
  logic [31:0] DataMemOutW;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0, ld_wdata = 32'h0;
  logic        ld_gnt, ld_done;
  logic [31:0] ld_rdata;
  logic        mem_timeout;

  mem_access_ctrl_if mif ();

  mem_access_ctrl #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .ALUOutE(ALUOutE),
    .StoreConverterE(StoreConverterE), .StallM(StallM), .DataMemOutW(DataMemOutW),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem(mif), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_dout = 32'h0;
  logic [31:0] exp_ldr = 32'h0;
  logic        exp_to = 1'b0;
  int          exp_starve = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %08h expected %08h", tag, obs, expv);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from the IDLE cycle in which it is granted up to the IDLE cycle
  // after completion. lat = cycle of mem_ready (lat > TO means never ready).
  task automatic do_access(input bit is_ld, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat,
                           input logic [31:0] rdata);
    bit preq;
    int last;
    preq = MemReadE | MemWriteE;
    last = (lat < int'(TO)) ? lat : int'(TO);
    // stray mem_ready in IDLE must be ignored
    mif.mem_ready = 1'($urandom_range(0, 1));
    mif.mem_rdata = $urandom;
    #1;
    chk1("idle_req", mif.mem_req, 1'b0);
    chk1("idle_stall", StallM, preq);
    tick();
    for (int c = 1; c <= last; c++) begin
      mif.mem_ready = (c == lat);
      mif.mem_rdata = (c == lat) ? rdata : $urandom;
      #1;
      chk1("acc_req", mif.mem_req, 1'b1);
      chk1("acc_we", mif.mem_we, we);
      chk("acc_addr", mif.mem_addr, addr);
      chk("acc_wdata", mif.mem_wdata, wdata);
      chk1("acc_gnt", ld_gnt, is_ld && (c == 1));
      chk1("acc_done", ld_done, 1'b0);
      chk1("acc_stall", StallM, preq && !(!is_ld && (c == last)));
      tick();
    end
    mif.mem_ready = 1'b0;
    if (lat > int'(TO)) exp_to = 1'b1;
    if (!we) begin
      if (is_ld) exp_ldr = (lat <= int'(TO)) ? rdata : 32'h0;
      else       exp_dout = (lat <= int'(TO)) ? rdata : 32'h0;
    end
    chk1("end_req", mif.mem_req, 1'b0);
    chk1("end_done", ld_done, is_ld);
    chk1("end_gnt", ld_gnt, 1'b0);
    chk("end_dout", DataMemOutW, exp_dout);
    chk("end_ldr", ld_rdata, exp_ldr);
    chk1("end_timeout", mem_timeout, exp_to);
  endtask

  task automatic set_pipe(input bit pend, input int kind, input logic [31:0] a,
                          input logic [31:0] d);
    MemReadE  = pend && (kind != 1);
    MemWriteE = pend && (kind != 0);
    ALUOutE = a;
    StoreConverterE = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  initial begin
    bit          p_pend, l_pend, ld_wins;
    int          p_kind, reissue, lat;
    logic [31:0] p_addr, p_data, rd, ldw, lda;

    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;
    // ---- reset state, StallM follows the pipeline request during reset
    MemReadE = 1'b1;
    #3;
    chk1("rst_req", mif.mem_req, 1'b0);
    chk1("rst_we", mif.mem_we, 1'b0);
    chk1("rst_gnt", ld_gnt, 1'b0);
    chk1("rst_done", ld_done, 1'b0);
    chk1("rst_timeout", mem_timeout, 1'b0);
    chk("rst_dout", DataMemOutW, 32'h0);
    chk("rst_ldr", ld_rdata, 32'h0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk1("rst_stall", StallM, 1'b1);
    MemReadE = 1'b0;
    #1;
    chk1("rst_stall0", StallM, 1'b0);
    @(posedge clk); #1; reset = 1'b1;
    tick();

    // ---- pipeline read at 0x100, ready on 3rd PIPE cycle
    set_pipe(1'b1, 0, 32'h100, 32'h5555_0000);
    do_access(1'b0, 1'b0, 32'h100, 32'h5555_0000, 3, 32'hDEADBEEF);
    chk("dout_deadbeef", DataMemOutW, 32'hDEADBEEF);
    set_pipe(1'b0, 0, 32'h0, 32'h0);

    // ---- loader and pipeline write arrive together: pipeline first
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h200; ld_wdata = 32'h1111_2222;
    set_pipe(1'b1, 1, 32'h300, 32'hCAFE0001);
    do_access(1'b0, 1'b1, 32'h300, 32'hCAFE0001, 2, 32'h0);
    set_pipe(1'b0, 0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 32'h200, 32'h1111_2222, 2, 32'hA5A5_0200);
    ld_req = 1'b0;
    tick();

    // ---- starvation: two pipeline grants, then the loader
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h500; ld_wdata = 32'h7777_0500;
    set_pipe(1'b1, 0, 32'h10, 32'h0);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h0000_0010);
    set_pipe(1'b1, 0, 32'h14, 32'h0);
    do_access(1'b0, 1'b0, 32'h14, 32'h0, 1, 32'h0000_0014);
    set_pipe(1'b1, 0, 32'h18, 32'h0);
    do_access(1'b1, 1'b1, 32'h500, 32'h7777_0500, 2, 32'h0);
    ld_req = 1'b0;
    do_access(1'b0, 1'b0, 32'h18, 32'h0, 1, 32'h0000_0018);
    set_pipe(1'b0, 0, 32'h0, 32'h0);
    tick();

    // ---- timeout: ready never comes
    set_pipe(1'b1, 0, 32'h40, 32'h0);
    do_access(1'b0, 1'b0, 32'h40, 32'h0, int'(TO) + 1, 32'h0);
    chk("timeout_dout", DataMemOutW, 32'h0);
    set_pipe(1'b0, 0, 32'h0, 32'h0);
    tick();
    chk1("timeout_sticky", mem_timeout, 1'b1);

    // ---- reset on the 2nd LOAD cycle aborts the access
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h400; ld_wdata = 32'h0;
    tick();
    chk1("ab_gnt", ld_gnt, 1'b1);
    chk1("ab_req1", mif.mem_req, 1'b1);
    tick();
    chk1("ab_req2", mif.mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk1("ab_req_now", mif.mem_req, 1'b0);
    chk1("ab_done_now", ld_done, 1'b0);
    chk1("ab_timeout_clr", mem_timeout, 1'b0);
    chk("ab_ldr", ld_rdata, 32'h0);
    ld_req = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    exp_dout = 32'h0; exp_ldr = 32'h0; exp_to = 1'b0; exp_starve = 0;
    for (int i = 0; i < 3; i++) begin
      mif.mem_ready = 1'($urandom_range(0, 1));
      tick();
      chk1("ab_idle_req", mif.mem_req, 1'b0);
      chk1("ab_no_done", ld_done, 1'b0);
      chk("ab_dout", DataMemOutW, 32'h0);
    end
    mif.mem_ready = 1'b0;

    // ---- randomized traffic against the transaction model
    for (int it = 0; it < 40; it++) begin
      p_pend = 1'($urandom_range(0, 1));
      l_pend = 1'($urandom_range(0, 1));
      p_kind = $urandom_range(0, 2);
      p_addr = $urandom; p_data = $urandom;
      lda = $urandom; ldw = $urandom;
      ld_we = 1'($urandom_range(0, 1));
      ld_addr = lda; ld_wdata = ldw;
      reissue = 0;
      while (p_pend || l_pend) begin
        ld_wins = l_pend && (!p_pend || (exp_starve == int'(SL)));
        set_pipe(p_pend, p_kind, p_addr, p_data);
        ld_req = l_pend;
        if (ld_wins) exp_starve = 0;
        else if (l_pend) exp_starve = (exp_starve < int'(SL)) ? exp_starve + 1 : exp_starve;
        else exp_starve = 0;
        lat = ($urandom_range(0, 5) == 0) ? int'(TO) + 1 : $urandom_range(1, TO);
        rd = $urandom;
        if (ld_wins) begin
          do_access(1'b1, ld_we, lda, ldw, lat, rd);
          l_pend = 1'b0;
          ld_req = 1'b0;
        end else begin
          do_access(1'b0, p_kind != 0, p_addr, p_data, lat, rd);
          if ((reissue < 3) && ($urandom_range(0, 1) == 1)) begin
            reissue++;
            p_kind = $urandom_range(0, 2);
            p_addr = $urandom; p_data = $urandom;
          end else begin
            p_pend = 1'b0;
          end
        end
      end
      set_pipe(1'b0, 0, 32'h0, 32'h0);
      ld_req = 1'b0;
      tick();
      exp_starve = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive pipeline grants allowed while the loader waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles an access waits for mem_ready.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemReadE  in  1  pipeline load request.
REQ-006 SHALL have port MemWriteE  in  1  pipeline store request.
REQ-007 SHALL have port ALUOutE  in  32  pipeline byte address.
REQ-008 SHALL have port StoreConverterE  in  32  pipeline store data.
REQ-009 SHALL have port StallM  out  1  pipeline hold request.
REQ-010 SHALL have port DataMemOutW  out  32  registered pipeline load data.
REQ-011 SHALL have port ld_req  in  1  loader/debug access request, level-held until ld_done.
REQ-012 SHALL have port ld_we  in  1  loader write enable.
REQ-013 SHALL have port ld_addr  in  32  loader address.
REQ-014 SHALL have port ld_wdata  in  32  loader write data.
REQ-015 SHALL have port ld_gnt  out  1  one-cycle pulse when the loader access starts.
REQ-016 SHALL have port ld_rdata  out  32  registered loader read data.
REQ-017 SHALL have port ld_done  out  1  one-cycle pulse when the loader access completes.
REQ-018 SHALL have port mem_req  out  1  memory access strobe, held until completion.
REQ-019 SHALL have port mem_we  out  1  memory write enable.
REQ-020 SHALL have port mem_addr  out  32  memory address.
REQ-021 SHALL have port mem_wdata  out  32  memory write data.
REQ-022 SHALL have port mem_rdata  in  32  memory read data, valid when mem_ready is high.
REQ-023 SHALL have port mem_ready  in  1  single-cycle completion from memory.
REQ-024 SHALL have port mem_timeout  out  1  sticky error flag.

Function
REQ-025 SHALL implement states IDLE, PIPE and LOAD.
REQ-026 In IDLE, SHALL select PIPE when a pipeline request exists (MemReadE|MemWriteE), unless ld_req=1 and starve_cnt=STARVE_LIMIT.
REQ-027 In IDLE, SHALL select LOAD when ld_req=1 and PIPE is not selected.
REQ-028 SHALL register address, data and we on grant and drive mem_addr, mem_wdata and mem_we from those registers, stable while mem_req=1.
REQ-029 MemReadE and MemWriteE both high SHALL be treated as a write.
REQ-030 mem_req SHALL be 1 in PIPE and LOAD and 0 in IDLE.
REQ-031 The cycle with mem_ready=1 completes the access, and the next state SHALL be IDLE: minimum 2 cycles per access, with at least 1 IDLE cycle between accesses.
REQ-032 StallM SHALL equal pipe_req & ~(state==PIPE & (mem_ready | timeout_hit)), combinationally.
REQ-033 The pipeline holds its inputs stable while StallM=1; a request withdrawn mid-access SHALL be ignored and the access SHALL still complete.
REQ-034 On pipeline-read completion, DataMemOutW SHALL load mem_rdata (0 on timeout) and hold it until the next pipeline read completes; pipeline writes SHALL leave it unchanged.
REQ-035 ld_gnt SHALL pulse in the first LOAD cycle.
REQ-036 On loader completion, ld_done SHALL pulse and ld_rdata SHALL load mem_rdata (0 on timeout, unchanged on a write).
REQ-037 starve_cnt SHALL increment on each PIPE grant while ld_req=1, saturate at STARVE_LIMIT, and clear on a LOAD grant or when ld_req=0.
REQ-038 A per-access cycle counter SHALL clear on grant; when it reaches TIMEOUT without mem_ready, the access SHALL complete as timed out and mem_timeout SHALL set and remain set until reset.
REQ-039 mem_ready while in IDLE SHALL be ignored.

Reset
REQ-040 When reset=0, asynchronously: state=IDLE, mem_req=0, mem_we=0, ld_gnt=0, ld_done=0, mem_timeout=0, all data/address registers=0, counters=0, and StallM SHALL equal pipe_req.
REQ-041 Reset during an access SHALL abort it with no ld_done pulse and no DataMemOutW update.

Structure
REQ-042 Package mem_ctrl_pkg SHALL hold the state enum and the STARVE_LIMIT and TIMEOUT defaults.
REQ-043 One sub-module, mem_access_timer (per-access timeout counter), SHALL be used; arbitration and the FSM SHALL stay in mem_access_ctrl.

Verification
REQ-044 Bench SHALL cover: pipeline read at 0x100, mem_ready on the 3rd PIPE cycle, mem_rdata=0xDEADBEEF -> StallM=1 for 3 cycles, DataMemOutW=0xDEADBEEF the following cycle.
REQ-045 Bench SHALL cover: ld_req and MemWriteE rising together in IDLE -> PIPE granted with mem_we=1, ld_gnt=0 until pipe completion plus 1 IDLE cycle.
REQ-046 Bench SHALL cover: STARVE_LIMIT=2, continuous pipeline requests, ld_req held -> LOAD granted on the 3rd arbitration with ld_gnt pulse and StallM=1 throughout.
REQ-047 Bench SHALL cover: TIMEOUT=4, mem_ready never asserted -> mem_req drops after 4 PIPE cycles, mem_timeout=1, StallM released, DataMemOutW=0.
REQ-048 Bench SHALL cover: reset=0 on the 2nd LOAD cycle -> mem_req=0 immediately, no ld_done pulse, state=IDLE after release.
